scratch_timing: RTL and testbench

SCRATCH_TIMING -- requirements
Module: scratch_timing

---
 rtl/scratch_timing.sv | 114 +++++++++++
 tb/tb_scratch_timing.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/scratch_timing.sv
// Video timing generator: pixel enables, H/V counters, blanking and sync.
// All timing outputs move together on the pixel enable edge.
module scratch_timing #(
  parameter int H_TOTAL  = 384,
  parameter int H_ACTIVE = 256,
  parameter int HS_START = 288,
  parameter int HS_LEN   = 32,
  parameter int V_TOTAL  = 264,
  parameter int V_ACTIVE = 224,
  parameter int VS_START = 240,
  parameter int VS_LEN   = 8,
  parameter int DLY      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] hs_adj,
  output logic       pxl2_cen,
  output logic       pxl_cen,
  output logic [8:0] H,
  output logic [8:0] V,
  output logic       LHBL,
  output logic       LVBL,
  output logic       LHBL_dly,
  output logic       LVBL_dly,
  output logic       HS,
  output logic       VS,
  output logic       frame
);

  logic [2:0]     cnt;
  logic [3:0]     adj_q;
  logic [3:0]     adj_nxt;
  logic           h_wrap;
  logic           v_wrap;
  logic [8:0]     h_nxt;
  logic [8:0]     v_nxt;
  logic [9:0]     hs_sum;
  logic [9:0]     hs_eff;
  logic [9:0]     hs_diff;
  logic [9:0]     hs_pos;
  logic           hs_nxt;
  logic           vs_nxt;
  logic           lhbl_nxt;
  logic           lvbl_nxt;
  logic [DLY-1:0] lhbl_sr;
  logic [DLY-1:0] lvbl_sr;

  always_comb begin
    h_wrap = H == 9'(H_TOTAL - 1);
    v_wrap = V == 9'(V_TOTAL - 1);
    h_nxt  = h_wrap ? 9'd0 : H + 9'd1;
    v_nxt  = V;
    if (h_wrap) v_nxt = v_wrap ? 9'd0 : V + 9'd1;
    adj_nxt = (h_wrap && v_wrap) ? hs_adj : adj_q;
    // 10-bit two's complement sum, folded back into 0..H_TOTAL-1
    hs_sum = 10'(HS_START) + {{6{adj_nxt[3]}}, adj_nxt};
    hs_eff = hs_sum;
    unique case (1'b1)
      hs_sum[9]:                hs_eff = hs_sum + 10'(H_TOTAL);
      hs_sum >= 10'(H_TOTAL):   hs_eff = hs_sum - 10'(H_TOTAL);
      default:                  hs_eff = hs_sum;
    endcase
    hs_diff  = {1'b0, h_nxt} - hs_eff;
    hs_pos   = hs_diff[9] ? hs_diff + 10'(H_TOTAL) : hs_diff;
    hs_nxt   = hs_pos < 10'(HS_LEN);
    vs_nxt   = ({1'b0, v_nxt} >= 10'(VS_START)) &&
               ({1'b0, v_nxt} <  10'(VS_START + VS_LEN));
    lhbl_nxt = {1'b0, h_nxt} < 10'(H_ACTIVE);
    lvbl_nxt = {1'b0, v_nxt} < 10'(V_ACTIVE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      pxl2_cen <= 1'b0;
      pxl_cen  <= 1'b0;
      frame    <= 1'b0;
      H        <= '0;
      V        <= '0;
      adj_q    <= '0;
      LHBL     <= 1'b1;
      LVBL     <= 1'b1;
      HS       <= 1'b0;
      VS       <= 1'b0;
      lhbl_sr  <= '1;
      lvbl_sr  <= '1;
    end else begin
      cnt      <= cnt + 3'd1;
      pxl2_cen <= cnt[1:0] == 2'd3;
      pxl_cen  <= cnt == 3'd7;
      frame    <= pxl_cen && h_wrap && v_wrap;
      if (pxl_cen) begin
        H     <= h_nxt;
        V     <= v_nxt;
        adj_q <= adj_nxt;
        LHBL  <= lhbl_nxt;
        LVBL  <= lvbl_nxt;
        HS    <= hs_nxt;
        VS    <= vs_nxt;
        // shift in the blanking level of the pixel being left
        for (int i = DLY - 1; i > 0; i--) begin
          lhbl_sr[i] <= lhbl_sr[i-1];
          lvbl_sr[i] <= lvbl_sr[i-1];
        end
        lhbl_sr[0] <= LHBL;
        lvbl_sr[0] <= LVBL;
      end
    end
  end

  assign LHBL_dly = lhbl_sr[DLY-1];
  assign LVBL_dly = lvbl_sr[DLY-1];

endmodule

// File: tb/tb_scratch_timing.sv
// Bench for scratch_timing using a reduced raster so whole frames fit.
// Expected values come from pixel-index arithmetic, not the RTL structure.
module tb_scratch_timing;

  localparam int HT  = 48;
  localparam int HA  = 32;
  localparam int HSS = 44;
  localparam int HSL = 6;
  localparam int VT  = 20;
  localparam int VA  = 16;
  localparam int VSS = 17;
  localparam int VSL = 2;
  localparam int DL  = 2;
  localparam int FR  = HT * VT;
  localparam int FRC = FR * 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] hs_adj = 4'd0;
  logic       pxl2_cen, pxl_cen;
  logic [8:0] H, V;
  logic       LHBL, LVBL, LHBL_dly, LVBL_dly, HS, VS, frame;

  scratch_timing #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .HS_START(HSS), .HS_LEN(HSL),
    .V_TOTAL(VT), .V_ACTIVE(VA), .VS_START(VSS), .VS_LEN(VSL),
    .DLY(DL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hs_adj(hs_adj),
    .pxl2_cen(pxl2_cen), .pxl_cen(pxl_cen),
    .H(H), .V(V),
    .LHBL(LHBL), .LVBL(LVBL),
    .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly),
    .HS(HS), .VS(VS), .frame(frame)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int k = 0;
  int n = 0;
  int adj_cur = 0;
  logic hs_prev = 1'b0;

  typedef struct {
    int k;
    int h;
    int v;
    bit lhbl;
    bit lhbl_dly;
    bit pxl2;
    bit pxl;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(int kk, int hh, int vv, bit lb, bit ld,
                              bit p2, bit p1);
    vec_t r;
    r.k = kk; r.h = hh; r.v = vv; r.lhbl = lb;
    r.lhbl_dly = ld; r.pxl2 = p2; r.pxl = p1;
    return r;
  endfunction

  function automatic int hs_eff(int adj);
    return ((HSS + adj) % HT + HT) % HT;
  endfunction

  function automatic bit hs_at(int h, int adj);
    int e = hs_eff(adj);
    for (int i = 0; i < HSL; i++)
      if ((e + i) % HT == h) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [26:0] act_vec();
    return {pxl2_cen, pxl_cen, H, V, LHBL, LVBL,
            LHBL_dly, LVBL_dly, HS, VS, frame};
  endfunction

  function automatic logic [26:0] exp_vec();
    int  h = n % HT;
    int  v = (n / HT) % VT;
    int  m = n - DL;
    bit  p2 = (k >= 4) && (k % 4 == 0);
    bit  p1 = (k >= 8) && (k % 8 == 0);
    bit  inc = (k >= 9) && ((k - 1) % 8 == 0);
    bit  fr = inc && (n % FR == 0);
    bit  lb = h < HA;
    bit  vb = v < VA;
    bit  ld = (m < 0) ? 1'b1 : ((m % HT) < HA);
    bit  vd = (m < 0) ? 1'b1 : (((m / HT) % VT) < VA);
    bit  hs = (n == 0) ? 1'b0 : hs_at(h, adj_cur);
    bit  vs = (n == 0) ? 1'b0 : (v >= VSS && v < VSS + VSL);
    return {p2, p1, 9'(h), 9'(v), lb, vb, ld, vd, hs, vs, fr};
  endfunction

  task automatic check(string name, logic [26:0] act, logic [26:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s k=%0d actual=%h expected=%h",
                  name, k, act, exp);
  endtask

  task automatic model_reset();
    k = 0; n = 0; adj_cur = 0; hs_prev = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
    if (k >= 9 && (k - 1) % 8 == 0) begin
      n++;
      if (n % FR == 0) adj_cur = int'($signed(hs_adj));
    end
    check("cycle", act_vec(), exp_vec());
    if (HS && !hs_prev && H != 9'd0 && n > 1)
      check("hs_rise", 27'(H), 27'(hs_eff(adj_cur)));
    hs_prev = HS;
  endtask

  localparam logic [26:0] RST_VEC =
    {1'b0, 1'b0, 9'd0, 9'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    int guard;
    vecs[0]  = mk(1,    0,  0, 1, 1, 0, 0);
    vecs[1]  = mk(4,    0,  0, 1, 1, 1, 0);
    vecs[2]  = mk(8,    0,  0, 1, 1, 1, 1);
    vecs[3]  = mk(9,    1,  0, 1, 1, 0, 0);
    vecs[4]  = mk(12,   1,  0, 1, 1, 1, 0);
    vecs[5]  = mk(256,  31, 0, 1, 1, 1, 1);
    vecs[6]  = mk(257,  32, 0, 0, 1, 0, 0);
    vecs[7]  = mk(272,  33, 0, 0, 1, 1, 1);
    vecs[8]  = mk(273,  34, 0, 0, 0, 0, 0);
    vecs[9]  = mk(384,  47, 0, 0, 0, 1, 1);
    vecs[10] = mk(385,  0,  1, 1, 0, 0, 0);
    vecs[11] = mk(401,  2,  1, 1, 1, 0, 0);
    vecs[12] = mk(6145, 0, 16, 1, 0, 0, 0);
    vecs[13] = mk(7681, 0,  0, 1, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("reset", act_vec(), RST_VEC);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    foreach (vecs[i]) begin
      guard = 0;
      while (k < vecs[i].k && guard < 20000) begin
        step();
        guard++;
      end
      check("vec", 27'({H, V, LHBL, LHBL_dly, pxl2_cen, pxl_cen}),
            27'({9'(vecs[i].h), 9'(vecs[i].v), vecs[i].lhbl,
                 vecs[i].lhbl_dly, vecs[i].pxl2, vecs[i].pxl}));
    end

    for (int i = 0; i < 3 * FRC; i++) begin
      step();
      if (i == FRC / 2) hs_adj = 4'b1000;
      else if (i == FRC + FRC / 3) hs_adj = 4'd7;
      else if (i == 2 * FRC + 100) hs_adj = 4'($urandom);
      else if ($urandom_range(0, 1999) == 0) hs_adj = 4'($urandom);
    end

    guard = 0;
    while (!((n % HT) == 40 && ((n / HT) % VT) == 15) && guard < 2 * FRC) begin
      step();
      guard++;
    end
    if (guard >= 2 * FRC) begin
      checks++;
      $display("FAIL rst_search k=%0d actual=timeout required=H40V15", k);
    end
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst", act_vec(), RST_VEC);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold", act_vec(), RST_VEC);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (1000) step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
